// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO configuration register block: window base,
// register offsets, reset values and a byte-enable helper.
package mmio_pkg;

  localparam logic [31:0] CONF_BASE_DEF = 32'hBFAF_0000;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] SWITCH_OFF  = 16'h0004;
  localparam logic [15:0] BTN_OFF     = 16'h0008;
  localparam logic [15:0] TIMER_OFF   = 16'h000C;
  localparam logic [15:0] COMPARE_OFF = 16'h0010;
  localparam logic [15:0] SCRATCH_OFF = 16'h0014;

  localparam logic [15:0] LED_RST     = '0;
  localparam logic [15:0] BTN_RST     = '0;
  localparam logic [31:0] TIMER_RST   = '0;
  localparam logic [31:0] COMPARE_RST = '0;
  localparam logic [31:0] SCRATCH_RST = '0;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer with optional rising-edge detector on the
// synchronized level (rise is a one-cycle pulse).
module btn_edge_sync #(
  parameter int unsigned W        = 16,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= '0;
      level <= '0;
    end else begin
      meta  <= d;
      level <= meta;
    end
  end

  if (EDGE_DET) begin : g_edge
    logic [W-1:0] prev;
    always_ff @(posedge clk) begin
      if (reset) prev <= '0;
      else       prev <= level;
    end
    assign rise = level & ~prev;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

// File: rtl/mmio_confreg.sv
// Configuration register window in front of the data RAM. The timer, compare
// register and irq exist only when CONFREG_TIMER_EN is defined.
module mmio_confreg
  import mmio_pkg::*;
#(
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
  parameter int unsigned TIMER_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [15:0] switch,
  input  logic [15:0] btn_key,
  output logic [15:0] led,
  output logic        irq
);

  logic        hit, wr, rd;
  logic [15:0] off;
  logic [31:0] wmask;
  logic [15:0] sw_level, sw_rise_unused;
  logic [15:0] btn_level_unused, btn_rise;
  logic [15:0] btn_flags, btn_clr;
  logic [31:0] scratch;
  logic [31:0] timer_ext, compare_ext;
  logic [31:0] local_rd, rd_data;
  logic        rd_sel;

  assign hit   = cpu_en && (cpu_addr[31:16] == CONF_BASE[31:16]);
  assign off   = {cpu_addr[15:2], 2'b00};
  assign wr    = hit && (cpu_wen != '0);
  assign rd    = hit && (cpu_wen == '0);
  assign wmask = byte_mask(cpu_wen);

  assign ram_en    = hit ? 1'b0 : cpu_en;
  assign ram_wen   = hit ? '0 : cpu_wen;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;

  btn_edge_sync #(.W(16), .EDGE_DET(1'b0)) u_sw_sync (
    .clk(clk), .reset(reset), .d(switch), .level(sw_level), .rise(sw_rise_unused)
  );

  btn_edge_sync #(.W(16), .EDGE_DET(1'b1)) u_btn_sync (
    .clk(clk), .reset(reset), .d(btn_key), .level(btn_level_unused), .rise(btn_rise)
  );

  assign btn_clr = (wr && off == BTN_OFF) ? (cpu_wdata[15:0] & wmask[15:0]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      led       <= LED_RST;
      btn_flags <= BTN_RST;
      scratch   <= SCRATCH_RST;
    end else begin
      if (wr && off == LED_OFF)
        led <= (led & ~wmask[15:0]) | (cpu_wdata[15:0] & wmask[15:0]);
      if (wr && off == SCRATCH_OFF)
        scratch <= (scratch & ~wmask) | (cpu_wdata & wmask);
      // A new edge overrides a simultaneous write-1-to-clear of the same bit.
      btn_flags <= (btn_flags & ~btn_clr) | btn_rise;
    end
  end

`ifdef CONFREG_TIMER_EN
  logic [TIMER_W-1:0] timer_q, compare_q;
  logic               irq_q;

  assign timer_ext   = 32'(timer_q);
  assign compare_ext = 32'(compare_q);
  assign irq         = irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= TIMER_W'(TIMER_RST);
      compare_q <= TIMER_W'(COMPARE_RST);
      irq_q     <= 1'b0;
    end else begin
      if (wr && off == TIMER_OFF)
        timer_q <= TIMER_W'((timer_ext & ~wmask) | (cpu_wdata & wmask));
      else
        timer_q <= timer_q + TIMER_W'(1);
      // Match uses the pre-write count; a COMPARE write clears irq over a match.
      if (wr && off == COMPARE_OFF) begin
        compare_q <= TIMER_W'((compare_ext & ~wmask) | (cpu_wdata & wmask));
        irq_q     <= 1'b0;
      end else if (timer_q == compare_q && compare_q != '0) begin
        irq_q <= 1'b1;
      end
    end
  end
`else
  assign timer_ext   = '0;
  assign compare_ext = '0;
  assign irq         = 1'b0;
`endif

  always_comb begin
    local_rd = '0;
    case (off)
      LED_OFF:     local_rd = {16'h0000, led};
      SWITCH_OFF:  local_rd = {16'h0000, sw_level};
      BTN_OFF:     local_rd = {16'h0000, btn_flags};
      TIMER_OFF:   local_rd = timer_ext;
      COMPARE_OFF: local_rd = compare_ext;
      SCRATCH_OFF: local_rd = scratch;
      default:     local_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_sel <= rd;
      if (rd) rd_data <= local_rd;
    end
  end

  assign cpu_rdata = rd_sel ? rd_data : ram_rdata;

endmodule
